// File: rtl/mod_vga_timing_gen_pkg.sv
// Shared constants, types and helpers for the parametrised VGA timing generator.
package vga_timing_pkg;

   // 640x480@60 (25.175 MHz pixel clock), negative sync polarity
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FRONT  = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BACK   = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FRONT  = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BACK   = 33;
   localparam bit VGA640_H_POL    = 1'b0;
   localparam bit VGA640_V_POL    = 1'b0;

   // 800x600@60 (40 MHz pixel clock), positive sync polarity
   localparam int VGA800_H_ACTIVE = 800;
   localparam int VGA800_H_FRONT  = 40;
   localparam int VGA800_H_SYNC   = 128;
   localparam int VGA800_H_BACK   = 88;
   localparam int VGA800_V_ACTIVE = 600;
   localparam int VGA800_V_FRONT  = 1;
   localparam int VGA800_V_SYNC   = 4;
   localparam int VGA800_V_BACK   = 23;
   localparam bit VGA800_H_POL    = 1'b1;
   localparam bit VGA800_V_POL    = 1'b1;

   // Per-pixel control bits carried alongside the renderer pipeline; 1 = asserted
   typedef struct packed {
      logic act;
      logic hs;
      logic vs;
   } vga_ctl_t;

   // Full line length in pixels, or full frame length in lines
   function automatic int total_len(input int active, input int front,
                                    input int sync, input int back);
      return active + front + sync + back;
   endfunction

   function automatic int h_total(input int active, input int front,
                                  input int sync, input int back);
      return total_len(active, front, sync, back);
   endfunction

   function automatic int v_total(input int active, input int front,
                                  input int sync, input int back);
      return total_len(active, front, sync, back);
   endfunction

endpackage

// File: rtl/mod_vga_timing_gen_if.sv
// Pixel-side bundle: renderer colour in, counters/strobes/VGA pins out.
interface mod_vga_timing_gen_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic          in_vga_r;
   logic          in_vga_g;
   logic          in_vga_b;
   logic [XW-1:0] out_vga_current_x;
   logic [YW-1:0] out_vga_current_y;
   logic          out_line_start;
   logic          out_frame_start;
   logic          out_vga_r;
   logic          out_vga_g;
   logic          out_vga_b;
   logic          out_vga_hsync;
   logic          out_vga_vsync;

   modport master (
      input  in_vga_r, in_vga_g, in_vga_b,
      output out_vga_current_x, out_vga_current_y,
      output out_line_start, out_frame_start,
      output out_vga_r, out_vga_g, out_vga_b,
      output out_vga_hsync, out_vga_vsync
   );

   modport slave (
      output in_vga_r, in_vga_g, in_vga_b,
      input  out_vga_current_x, out_vga_current_y,
      input  out_line_start, out_frame_start,
      input  out_vga_r, out_vga_g, out_vga_b,
      input  out_vga_hsync, out_vga_vsync
   );
endinterface

// File: rtl/mod_vga_delay_line.sv
// Enable-gated shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module mod_vga_delay_line #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic unused_ctl;
         assign unused_ctl = clk ^ clr ^ en;
         assign dout = din;
      end else begin : g_shift
         logic [DEPTH-1:0][WIDTH-1:0] stage_q;
         logic [DEPTH-1:0][WIDTH-1:0] stage_d;

         // Shift one stage per enable, newest sample enters at stage 0
         always_comb begin
            stage_d = stage_q;
            if (en) begin
               stage_d[0] = din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage_d[i] = stage_q[i-1];
               end
            end
         end

         // Stage registers, cleared to all-zero (inactive) on clear
         always_ff @(posedge clk) begin
            if (clr) begin
               stage_q <= '0;
            end else begin
               stage_q <= stage_d;
            end
         end

         assign dout = stage_q[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/mod_vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, strobes, and a delayed,
// registered output stage aligned to a PIPE_DELAY-deep renderer.
module mod_vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = VGA640_H_ACTIVE,
   parameter int H_FRONT    = VGA640_H_FRONT,
   parameter int H_SYNC     = VGA640_H_SYNC,
   parameter int H_BACK     = VGA640_H_BACK,
   parameter int V_ACTIVE   = VGA640_V_ACTIVE,
   parameter int V_FRONT    = VGA640_V_FRONT,
   parameter int V_SYNC     = VGA640_V_SYNC,
   parameter int V_BACK     = VGA640_V_BACK,
   parameter bit H_SYNC_POL = VGA640_H_POL,
   parameter bit V_SYNC_POL = VGA640_V_POL,
   parameter int PIPE_DELAY = 2,
   parameter int XW         = 10,
   parameter int YW         = 10
) (
   input  logic                  in_clk_25_175_mhz,
   input  logic                  in_reset,
   input  logic                  in_pix_en,
   mod_vga_timing_gen_if.master  vga
);

   localparam int H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   // Sync windows can end exactly at 2^XW, so decode compares run one bit wider
   localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
   localparam logic [XW:0]   H_ACT_LIM = (XW+1)'(H_ACTIVE);
   localparam logic [XW:0]   HS_BEGIN  = (XW+1)'(H_ACTIVE + H_FRONT);
   localparam logic [XW:0]   HS_END    = (XW+1)'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [YW:0]   V_ACT_LIM = (YW+1)'(V_ACTIVE);
   localparam logic [YW:0]   VS_BEGIN  = (YW+1)'(V_ACTIVE + V_FRONT);
   localparam logic [YW:0]   VS_END    = (YW+1)'(V_ACTIVE + V_FRONT + V_SYNC);

   if ((H_TOTAL - 1) >= (1 << XW)) begin : g_err_xw
      $error("mod_vga_timing_gen: H_TOTAL-1 does not fit in XW bits");
   end
   if ((V_TOTAL - 1) >= (1 << YW)) begin : g_err_yw
      $error("mod_vga_timing_gen: V_TOTAL-1 does not fit in YW bits");
   end
   if ((H_SYNC == 0) || (V_SYNC == 0)) begin : g_err_sync
      $error("mod_vga_timing_gen: sync width must be non-zero");
   end
   if ((PIPE_DELAY < 0) || (PIPE_DELAY > 15)) begin : g_err_pipe
      $error("mod_vga_timing_gen: PIPE_DELAY must be 0..15");
   end

   logic [XW-1:0] h_q, h_d;
   logic [YW-1:0] v_q, v_d;
   logic [XW:0]   h_ext;
   logic [YW:0]   v_ext;
   vga_ctl_t      ctl0;
   vga_ctl_t      ctl_dly;
   logic [2:0]    rgb_q, rgb_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;

   // Raster position: h wraps each line, v advances on the h wrap
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (in_pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge in_clk_25_175_mhz) begin
      if (in_reset) begin
         h_q <= '0;
         v_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
      end
   end

   assign h_ext = {1'b0, h_q};
   assign v_ext = {1'b0, v_q};

   // Stage-0 decode of the current position; vsync is per line, so it follows v only
   always_comb begin
      ctl0     = '0;
      ctl0.act = (h_ext < H_ACT_LIM) && (v_ext < V_ACT_LIM);
      ctl0.hs  = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
      ctl0.vs  = (v_ext >= VS_BEGIN) && (v_ext < VS_END);
   end

   mod_vga_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_DELAY)
   ) u_delay (
      .clk  (in_clk_25_175_mhz),
      .clr  (in_reset),
      .en   (in_pix_en),
      .din  (ctl0),
      .dout (ctl_dly)
   );

   // Output stage: blank colour outside the active area and apply sync polarity
   always_comb begin
      rgb_d   = rgb_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      if (in_pix_en) begin
         rgb_d   = {3{ctl_dly.act}} & {vga.in_vga_r, vga.in_vga_g, vga.in_vga_b};
         hsync_d = ctl_dly.hs ? H_SYNC_POL : ~H_SYNC_POL;
         vsync_d = ctl_dly.vs ? V_SYNC_POL : ~V_SYNC_POL;
      end
   end

   // Output registers, idle at black with syncs deasserted
   always_ff @(posedge in_clk_25_175_mhz) begin
      if (in_reset) begin
         rgb_q   <= '0;
         hsync_q <= ~H_SYNC_POL;
         vsync_q <= ~V_SYNC_POL;
      end else begin
         rgb_q   <= rgb_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign vga.out_vga_current_x = h_q;
   assign vga.out_vga_current_y = v_q;
   assign vga.out_line_start    = in_pix_en && !in_reset && (h_q == '0);
   assign vga.out_frame_start   = in_pix_en && !in_reset && (h_q == '0) && (v_q == '0);
   assign vga.out_vga_r         = rgb_q[2];
   assign vga.out_vga_g         = rgb_q[1];
   assign vga.out_vga_b         = rgb_q[0];
   assign vga.out_vga_hsync     = hsync_q;
   assign vga.out_vga_vsync     = vsync_q;

endmodule
